// File: rtl/pacman_motion.sv
// Per-frame Pac-Man mover: turn/coast/stop against the maze, then ghost collision check.
// Frame walk: tick -> turn commit (+1) -> straight commit (+2) -> death (+3); no backpressure, ticks outside IDLE drop.

module check_wall (
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       wallEnable
);
    // Stub maze: a full-height column at X 340..347 and one short horizontal bar.
    assign wallEnable = ((x >= 10'd340) && (x <= 10'd347)) ||
                        ((x >= 10'd280) && (x <= 10'd319) && (y >= 10'd224) && (y <= 10'd231));
endmodule

module pacman_motion #(
    parameter logic [9:0] START_X = 10'd320,
    parameter logic [9:0] START_Y = 10'd232
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [9:0] ghost_redX,
    input  logic [9:0] ghost_redY,
    input  logic [9:0] ghost_greenX,
    input  logic [9:0] ghost_greenY,
    input  logic [9:0] ghost_aquaX,
    input  logic [9:0] ghost_aquaY,
    output logic [9:0] pacmanX,
    output logic [9:0] pacmanY,
    output logic [1:0] last_keypress,
    output logic       death
);
    typedef enum logic [2:0] {IDLE, TRY_REQ, TRY_CUR, COLLIDE, DEAD} state_t;

    state_t     state, next_state;
    logic       sync1, sync2, sync3, tick;
    logic [1:0] cur_dir, req_dir, probe_dir, key_dir;
    logic       moving, req_valid, key_valid;
    logic       capture, commit_req, commit_cur, stop, set_death;
    logic       edge_blk, free, hit;
    logic [9:0] cx, cy;
    logic [3:0] walls;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= frame_clk;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign tick = sync2 & ~sync3;

    always_comb begin
        key_valid = 1'b1;
        key_dir   = 2'd0;
        case (keycode)
            8'h07:   key_dir = 2'd0;
            8'h16:   key_dir = 2'd1;
            8'h04:   key_dir = 2'd2;
            8'h1A:   key_dir = 2'd3;
            default: key_valid = 1'b0;
        endcase
    end

    // One probe serves both attempts: the requested heading in TRY_REQ, the current one otherwise.
    assign probe_dir = (state == TRY_REQ) ? req_dir : cur_dir;

    // Screen-edge test uses the current position so the add/subtract never wraps.
    always_comb begin
        edge_blk = 1'b0;
        cx       = pacmanX;
        cy       = pacmanY;
        case (probe_dir)
            2'd0: begin edge_blk = (pacmanX >= 10'd632); cx = pacmanX + 10'd1; end
            2'd1: begin edge_blk = (pacmanY >= 10'd472); cy = pacmanY + 10'd1; end
            2'd2: begin edge_blk = (pacmanX == 10'd0);   cx = pacmanX - 10'd1; end
            default: begin edge_blk = (pacmanY == 10'd0); cy = pacmanY - 10'd1; end
        endcase
    end

    check_wall u_wall_tl (.x(cx),         .y(cy),         .wallEnable(walls[0]));
    check_wall u_wall_tr (.x(cx + 10'd7), .y(cy),         .wallEnable(walls[1]));
    check_wall u_wall_bl (.x(cx),         .y(cy + 10'd7), .wallEnable(walls[2]));
    check_wall u_wall_br (.x(cx + 10'd7), .y(cy + 10'd7), .wallEnable(walls[3]));

    assign free = ~edge_blk & ~(|walls);

    function automatic logic near(input logic [9:0] a, input logic [9:0] b);
        logic signed [10:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d > -11'sd8) && (d < 11'sd8);
    endfunction

    assign hit = (near(pacmanX, ghost_redX)   && near(pacmanY, ghost_redY))   ||
                 (near(pacmanX, ghost_greenX) && near(pacmanY, ghost_greenY)) ||
                 (near(pacmanX, ghost_aquaX)  && near(pacmanY, ghost_aquaY));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        commit_req = 1'b0;
        commit_cur = 1'b0;
        stop       = 1'b0;
        set_death  = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    capture    = 1'b1;
                    next_state = TRY_REQ;
                end
            end
            TRY_REQ: begin
                if (req_valid && free) begin
                    commit_req = 1'b1;
                    next_state = COLLIDE;
                end else begin
                    next_state = TRY_CUR;
                end
            end
            TRY_CUR: begin
                if (moving && free) commit_cur = 1'b1;
                else                stop       = 1'b1;
                next_state = COLLIDE;
            end
            COLLIDE: begin
                if (hit) begin
                    set_death  = 1'b1;
                    next_state = DEAD;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = DEAD;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pacmanX       <= START_X;
            pacmanY       <= START_Y;
            cur_dir       <= 2'd0;
            moving        <= 1'b0;
            req_dir       <= 2'd0;
            req_valid     <= 1'b0;
            last_keypress <= 2'd0;
            death         <= 1'b0;
        end else begin
            if (capture) begin
                req_valid <= key_valid;
                req_dir   <= key_dir;
            end
            if (commit_req || commit_cur) begin
                pacmanX <= cx;
                pacmanY <= cy;
            end
            if (commit_req) begin
                cur_dir       <= req_dir;
                moving        <= 1'b1;
                last_keypress <= req_dir;
            end
            if (stop)      moving <= 1'b0;
            if (set_death) death  <= 1'b1;
        end
    end
endmodule

// File: doc/pacman_motion.md
# pacman_motion

Per-frame Pac-Man position and heading controller, directly upstream of `color_mapper`. Once per video frame it reads the latched keyboard keycode and tries the requested turn against the maze. If the turn is blocked it keeps Pac-Man moving in its current direction, or stops him at a wall. It then checks the new box against the three ghosts. It drives `pacmanX`, `pacmanY`, `last_keypress` and `death`, which `color_mapper` consumes directly.

## Interface
- `START_X`, default 10'd320, reset X of the sprite's top-left corner; must be wall-free
- `START_Y`, default 10'd232, reset Y of the sprite's top-left corner; must be wall-free
- `Clk`  in  1  system clock; all state updates on its rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `frame_clk`  in  1  VGA vertical sync, asynchronous to `Clk`; its rising edge marks a new frame
- `keycode`  in  8  USB HID keycode: 0x07 D = right, 0x16 S = down, 0x04 A = left, 0x1A W = up; any other value = no request
- `ghost_redX`, `ghost_redY`, `ghost_greenX`, `ghost_greenY`, `ghost_aquaX`, `ghost_aquaY`  in  10 each  ghost top-left corners
- `pacmanX`, `pacmanY`  out  10 each  Pac-Man top-left corner, registered
- `last_keypress`  out  2  heading of the last successful move: 0 right, 1 down, 2 left, 3 up; registered
- `death`  out  1  sticky ghost-collision flag, registered

## Operation
- **Frame tick:** `frame_clk` goes through a 2-flop synchronizer plus a third flop for edge detection. `tick` is high for exactly one `Clk` cycle per rising edge.
- **Registers:**
  - `pos` (X, Y)
  - `cur_dir` (2 bits) and `moving` (1 bit)
  - `req_dir` and `req_valid`, captured from `keycode` on `tick`
  - `last_keypress`, `death`
- **Direction deltas:** right +1 X, down +1 Y, left −1 X, up −1 Y. One pixel per frame.
- **Wall probe:** a candidate box (cx, cy) is blocked under either condition:
  - any of the 4 corners (cx,cy), (cx+7,cy), (cx,cy+7), (cx+7,cy+7) returns `wallEnable=1` from one of four combinational `check_wall` instances;
  - the box is off-screen: left at X=0, up at Y=0, right at X≥632, down at Y≥472. Compute this before the add or subtract so no wrap-around occurs.
- **FSM states:** IDLE, TRY_REQ, TRY_CUR, COLLIDE, DEAD.
  - **IDLE:** on `tick`, capture `req_valid`/`req_dir` from `keycode` → TRY_REQ.
  - **TRY_REQ:** if `req_valid` and the candidate `pos + delta(req_dir)` is free, commit:
    - `pos` ← candidate
    - `cur_dir` ← `req_dir`, `moving` ← 1
    - `last_keypress` ← `req_dir`
    - then → COLLIDE.
    Otherwise → TRY_CUR.
  - **TRY_CUR:** if `moving` and the candidate `pos + delta(cur_dir)` is free, commit `pos` ← candidate, leaving `last_keypress` unchanged. Otherwise clear `moving` and leave `pos` unchanged. Either way → COLLIDE.
  - **COLLIDE:** for each ghost compute |pacmanX−gX|<8 && |pacmanY−gY|<8 on 11-bit signed differences. Any hit sets `death` ← 1 → DEAD; no hit → IDLE.
  - **DEAD:** absorbing. Outputs are frozen and ticks are ignored until `Reset`.
- **Turn rules:**
  - Reversing into the opposite direction is allowed whenever the candidate is free.
  - A blocked turn request is not remembered; it is re-evaluated each frame from the current `keycode`.
- **Reset values:**
  - `pacmanX` = START_X, `pacmanY` = START_Y
  - `last_keypress` = 0, `death` = 0
  - `moving` = 0, `cur_dir` = 0, state = IDLE, synchronizer flops = 0

## Timing
- **`tick`:** asserted in the cycle after the rising edge of `frame_clk` has propagated through the synchronizer. That is 2–3 `Clk` edges after the rise, depending on phase.
- **Move commit:**
  - accepted turn: position updates on the edge ending TRY_REQ, which is tick+1 edges;
  - straight-ahead move: on the edge ending TRY_CUR, tick+2 edges.
- **Collision:** `death` rises on the edge ending COLLIDE, at most tick+3 edges.
- **Ticks outside IDLE:** dropped. The frame period far exceeds the 4-cycle walk.
- **Async `Reset` mid-walk:** immediately forces all reset values; no partial commit survives.
- **Outputs:** stable between commits. `color_mapper` may sample them at any time; at most one pixel of the active frame can show the new position.

## Test plan
- **Reset defaults:** Reset pulse → `pacmanX`=320, `pacmanY`=232, `last_keypress`=0, `death`=0. Then 5 ticks with `keycode`=0 → position unchanged.
- **Turn, then coast:** `keycode`=0x07 for 3 ticks → `pacmanX`=323, `last_keypress`=0. Then `keycode`=0 for 2 ticks → `pacmanX`=325 (keeps moving).
- **Wall stop:** use a stub `check_wall` with a wall at X 340..347. Start at 320 moving right → X stops at 332 (corner X+7=339), and `moving` clears. Then `keycode`=0x1A → Y decrements and `last_keypress`=3.
- **Blocked turn:** moving left, request up into the stub wall → continues left, and `last_keypress` stays 2.
- **Screen edge:** START_X=0, `keycode`=0x04 → X stays 0, no wrap to 1023.
- **Collision:** red ghost at (327,232), Pac-Man at (320,232) moving right → after one tick `death`=1 within 3 edges. Further ticks change nothing; Reset clears `death`.
